// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I-subset CPU: sequences fetch/decode/exec/mem/writeback,
// drives the ALU operand/op selects and datapath strobes, and traps on illegal opcodes or memory timeouts.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR on mem_ready
// DECODE | classify held IR, trap if illegal
// EXEC   | ALU operation; branches/jumps retire here
// MEM    | LW/SW data access at ALU result address
// WB     | register file write, PC <= PC+4
// TRAP   | halted until reset
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        ALUSrc1,
   output logic        ALUSrc2,
   output logic [2:0]  AluOp,
   output logic [2:0]  imm_sel,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        halted,
   output logic [1:0]  trap_cause
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
   logic [2:0] alu_fn;
   logic mem_read_c, mem_write_c, ir_write_c, reg_write_c, pc_write_c;
   logic unused_instr_bits;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign unused_instr_bits = &{1'b0, instr[24:15], instr[11:7]};

   always_comb begin
      is_r     = (opcode == 7'b0110011) &&
                 (((f7 == 7'h00) && (f3 != 3'b010) && (f3 != 3'b011)) ||
                  ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      is_i     = (opcode == 7'b0010011) &&
                 ((f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111) ||
                  ((f3 == 3'b001) && (f7 == 7'h00)) ||
                  ((f3 == 3'b101) && ((f7 == 7'h00) || (f7 == 7'h20))));
      is_lw    = (opcode == 7'b0000011) && (f3 == 3'b010);
      is_sw    = (opcode == 7'b0100011) && (f3 == 3'b010);
      is_br    = (opcode == 7'b1100011) && ((f3 == 3'b000) || (f3 == 3'b001));
      is_jal   = (opcode == 7'b1101111);
      is_jalr  = (opcode == 7'b1100111) && (f3 == 3'b000);
      is_lui   = (opcode == 7'b0110111);
      is_auipc = (opcode == 7'b0010111);
      legal    = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui | is_auipc;
   end

   // funct7[5] selects SUB only for R-type; for ADDI it is an immediate bit.
   always_comb begin
      alu_fn = 3'b000;
      case (f3)
         3'b000:  alu_fn = (is_r && f7[5]) ? 3'b001 : 3'b000;
         3'b100:  alu_fn = 3'b010;
         3'b110:  alu_fn = 3'b011;
         3'b111:  alu_fn = 3'b100;
         3'b001:  alu_fn = 3'b101;
         3'b101:  alu_fn = f7[5] ? 3'b111 : 3'b110;
         default: alu_fn = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cause_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      cnt_d       = cnt_q + TMO_W'(1);
      ALUSrc1     = 1'b0;
      ALUSrc2     = 1'b0;
      AluOp       = 3'b000;
      imm_sel     = 3'd0;
      iord        = 1'b0;
      wb_sel      = 2'b00;
      pc_src      = 2'b00;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      pc_write_c  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_r || is_i) begin
               ALUSrc2 = is_i;
               AluOp   = alu_fn;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               ALUSrc2 = 1'b1;
               imm_sel = is_sw ? 3'd1 : 3'd0;
               state_d = S_MEM;
            end else if (is_br) begin
               AluOp      = 3'b001;
               imm_sel    = 3'd2;
               pc_write_c = 1'b1;
               pc_src     = ((!f3[0] && alu_zero) || (f3[0] && !alu_zero)) ? 2'b01 : 2'b00;
            end else if (is_jal) begin
               imm_sel     = 3'd4;
               reg_write_c = 1'b1;
               wb_sel      = 2'b10;
               pc_write_c  = 1'b1;
               pc_src      = 2'b01;
            end else if (is_jalr) begin
               ALUSrc2     = 1'b1;
               reg_write_c = 1'b1;
               wb_sel      = 2'b10;
               pc_write_c  = 1'b1;
               pc_src      = 2'b10;
            end else if (is_lui) begin
               imm_sel = 3'd3;
               wb_sel  = 2'b11;
               state_d = S_WB;
            end else if (is_auipc) begin
               ALUSrc1 = 1'b1;
               ALUSrc2 = 1'b1;
               imm_sel = 3'd3;
               state_d = S_WB;
            end
         end
         S_MEM: begin
            iord        = 1'b1;
            mem_read_c  = is_lw;
            mem_write_c = is_sw;
            if (mem_ready) begin
               if (is_sw) begin
                  pc_write_c = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_WB: begin
            reg_write_c = 1'b1;
            wb_sel      = is_lw ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
            imm_sel     = is_lui ? 3'd3 : 3'd0;
            pc_write_c  = 1'b1;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // Strobes are forced low for the whole reset assertion, not just from the next edge.
   assign mem_read   = mem_read_c  & rst_n;
   assign mem_write  = mem_write_c & rst_n;
   assign ir_write   = ir_write_c  & rst_n;
   assign reg_write  = reg_write_c & rst_n;
   assign pc_write   = pc_write_c  & rst_n;
   assign halted     = (state_q == S_TRAP);
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the hand-computed per-cycle output vector,
// a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        alu_zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        ALUSrc1, ALUSrc2, mem_read, mem_write, iord, ir_write, reg_write, pc_write, halted;
   logic [2:0]  AluOp, imm_sel;
   logic [1:0]  wb_sel, pc_src, trap_cause;

   int n_tests = 0;
   int n_fail  = 0;
   logic [20:0] exp_q[$];
   string       name_q[$];

   logic [20:0] FW, FR, DE, WBA;

   multicycle_ctrl #(.MEM_TIMEOUT(16), .TMO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .AluOp(AluOp), .imm_sel(imm_sel),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
      .halted(halted), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   // {Src1,Src2,AluOp,imm_sel,mem_read,mem_write,iord,ir_write,reg_write,wb_sel,pc_write,pc_src,halted,trap_cause}
   function automatic logic [20:0] v(input logic s1, input logic s2, input logic [2:0] op,
                                     input logic [2:0] imm, input logic mr, input logic mw,
                                     input logic io, input logic irw, input logic rw,
                                     input logic [1:0] wb, input logic pw, input logic [1:0] ps,
                                     input logic h, input logic [1:0] tc);
      return {s1, s2, op, imm, mr, mw, io, irw, rw, wb, pw, ps, h, tc};
   endfunction

   always @(negedge clk) begin
      logic [20:0] act, e;
      string nm;
      if (rst_n && exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {ALUSrc1, ALUSrc2, AluOp, imm_sel, mem_read, mem_write, iord, ir_write,
                reg_write, wb_sel, pc_write, pc_src, halted, trap_cause};
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: outputs=%06h expected=%06h", nm, act, e);
         end
      end
   end

   task automatic cyc(input string nm, input logic [31:0] ins, input logic rdy, input logic z,
                      input logic [20:0] e);
      instr     = ins;
      mem_ready = rdy;
      alu_zero  = z;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input string nm, input logic [31:0] ins, input logic [20:0] ex,
                          input logic [20:0] wb);
      cyc({nm, "_fetch"}, ins, 1'b1, 1'b0, FR);
      cyc({nm, "_decode"}, ins, 1'b1, 1'b0, DE);
      cyc({nm, "_exec"}, ins, 1'b1, 1'b0, ex);
      cyc({nm, "_wb"}, ins, 1'b1, 1'b0, wb);
   endtask

   task automatic check_strobes_off(input string nm);
      n_tests++;
      if ({mem_read, mem_write, ir_write, reg_write, pc_write} !== 5'b0) begin
         n_fail++;
         $display("FAIL %s: strobes=%05b expected=00000", nm,
                  {mem_read, mem_write, ir_write, reg_write, pc_write});
      end
   endtask

   task automatic reset_pulse(input string nm);
      rst_n = 1'b0;
      #1;
      check_strobes_off(nm);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4020D193;
   localparam logic [31:0] I_XOR   = 32'h0020C1B3;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_LW    = 32'h0000A183;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_JALR  = 32'h000100E7;
   localparam logic [31:0] I_LUI   = 32'h123451B7;
   localparam logic [31:0] I_AUIPC = 32'h00001197;
   localparam logic [31:0] I_SLT   = 32'h0020A1B3;

   initial begin
      FW  = v(0,0,3'b000,3'd0, 1,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00);
      FR  = v(0,0,3'b000,3'd0, 1,0,0,1,0, 2'b00, 0,2'b00, 0,2'b00);
      DE  = v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00);
      WBA = v(0,0,3'b000,3'd0, 0,0,0,0,1, 2'b00, 1,2'b00, 0,2'b00);

      #3;
      check_strobes_off("in_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      cyc("reset_state", I_ADD, 1'b0, 1'b0, FW);
      run_alu("add", I_ADD, v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);
      run_alu("sub", I_SUB, v(0,0,3'b001,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);
      run_alu("srai", I_SRAI, v(0,1,3'b111,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);
      run_alu("xor", I_XOR, v(0,0,3'b010,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);

      cyc("beq_t_fetch", I_BEQ, 1'b1, 1'b0, FR);
      cyc("beq_t_decode", I_BEQ, 1'b1, 1'b0, DE);
      cyc("beq_t_exec", I_BEQ, 1'b1, 1'b1, v(0,0,3'b001,3'd2, 0,0,0,0,0, 2'b00, 1,2'b01, 0,2'b00));
      cyc("beq_nt_fetch", I_BEQ, 1'b1, 1'b0, FR);
      cyc("beq_nt_decode", I_BEQ, 1'b1, 1'b0, DE);
      cyc("beq_nt_exec", I_BEQ, 1'b1, 1'b0, v(0,0,3'b001,3'd2, 0,0,0,0,0, 2'b00, 1,2'b00, 0,2'b00));

      cyc("lw_fetch", I_LW, 1'b1, 1'b0, FR);
      cyc("lw_decode", I_LW, 1'b1, 1'b0, DE);
      cyc("lw_exec", I_LW, 1'b1, 1'b0, v(0,1,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00));
      for (int i = 0; i < 3; i++)
         cyc("lw_mem_wait", I_LW, 1'b0, 1'b0, v(0,0,3'b000,3'd0, 1,0,1,0,0, 2'b00, 0,2'b00, 0,2'b00));
      cyc("lw_mem_ready", I_LW, 1'b1, 1'b0, v(0,0,3'b000,3'd0, 1,0,1,0,0, 2'b00, 0,2'b00, 0,2'b00));
      cyc("lw_wb", I_LW, 1'b1, 1'b0, v(0,0,3'b000,3'd0, 0,0,0,0,1, 2'b01, 1,2'b00, 0,2'b00));

      cyc("sw_fetch", I_SW, 1'b1, 1'b0, FR);
      cyc("sw_decode", I_SW, 1'b1, 1'b0, DE);
      cyc("sw_exec", I_SW, 1'b1, 1'b0, v(0,1,3'b000,3'd1, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00));
      cyc("sw_mem", I_SW, 1'b1, 1'b0, v(0,0,3'b000,3'd0, 0,1,1,0,0, 2'b00, 1,2'b00, 0,2'b00));

      cyc("jal_fetch", I_JAL, 1'b1, 1'b0, FR);
      cyc("jal_decode", I_JAL, 1'b1, 1'b0, DE);
      cyc("jal_exec", I_JAL, 1'b1, 1'b0, v(0,0,3'b000,3'd4, 0,0,0,0,1, 2'b10, 1,2'b01, 0,2'b00));
      cyc("jalr_fetch", I_JALR, 1'b1, 1'b0, FR);
      cyc("jalr_decode", I_JALR, 1'b1, 1'b0, DE);
      cyc("jalr_exec", I_JALR, 1'b1, 1'b0, v(0,1,3'b000,3'd0, 0,0,0,0,1, 2'b10, 1,2'b10, 0,2'b00));

      run_alu("lui", I_LUI, v(0,0,3'b000,3'd3, 0,0,0,0,0, 2'b11, 0,2'b00, 0,2'b00),
              v(0,0,3'b000,3'd3, 0,0,0,0,1, 2'b11, 1,2'b00, 0,2'b00));
      run_alu("auipc", I_AUIPC, v(1,1,3'b000,3'd3, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);

      // mem_ready arriving on the last allowed fetch cycle must win over the timeout
      for (int i = 0; i < 15; i++) cyc("fetch_slow", I_ADD, 1'b0, 1'b0, FW);
      run_alu("add_late", I_ADD, v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);

      cyc("rlw_fetch", I_LW, 1'b1, 1'b0, FR);
      cyc("rlw_decode", I_LW, 1'b1, 1'b0, DE);
      cyc("rlw_exec", I_LW, 1'b1, 1'b0, v(0,1,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00));
      cyc("rlw_mem", I_LW, 1'b0, 1'b0, v(0,0,3'b000,3'd0, 1,0,1,0,0, 2'b00, 0,2'b00, 0,2'b00));
      reset_pulse("reset_mid_lw");
      cyc("restart_fetch", I_ADD, 1'b0, 1'b0, FW);
      run_alu("add_after_rst", I_ADD, v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 0,2'b00), WBA);

      cyc("slt_fetch", I_SLT, 1'b1, 1'b0, FR);
      cyc("slt_decode", I_SLT, 1'b1, 1'b0, DE);
      for (int i = 0; i < 2; i++)
         cyc("slt_trap", I_SLT, 1'b1, 1'b0, v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 1,2'b01));
      reset_pulse("reset_from_trap");

      for (int i = 0; i < 16; i++) cyc("fetch_tmo_wait", I_ADD, 1'b0, 1'b0, FW);
      for (int i = 0; i < 2; i++)
         cyc("fetch_tmo_trap", I_ADD, 1'b1, 1'b0, v(0,0,3'b000,3'd0, 0,0,0,0,0, 2'b00, 0,2'b00, 1,2'b10));

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
